// File: rtl/balance_cntrl_pipe_pkg.sv
// Shared types, constants and arithmetic helpers
// for the balance controller slice.
package balance_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SOFT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int P_GAIN    = 5;
  localparam int D_SHIFT   = 6;
  localparam int SLEW_STEP = 64;

  localparam logic [11:0] STEER_LO  = 12'h200;
  localparam logic [11:0] STEER_HI  = 12'hE00;
  localparam logic [11:0] STEER_MID = 12'h7FF;

  function automatic logic signed [31:0] sat(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction

  function automatic logic signed [31:0] step_to(
    input logic signed [31:0] cur,
    input logic signed [31:0] tgt,
    input int                 step
  );
    if (tgt > cur + step)      step_to = cur + step;
    else if (tgt < cur - step) step_to = cur - step;
    else                       step_to = tgt;
  endfunction

endpackage

// File: rtl/balance_cntrl_pipe_if.sv
// Sensor/command inputs and motor-speed outputs
// of the balance controller.
interface balance_cntrl_pipe_if #(
  parameter int SPD_W = 12
);
  logic                    vld;
  logic signed [15:0]      ptch;
  logic signed [15:0]      ptch_rt;
  logic                    pwr_up;
  logic                    rider_off;
  logic [11:0]             steer_pot;
  logic                    en_steer;
  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;
  logic                    too_fast;
  logic                    running;

  modport master (
    output vld, ptch, ptch_rt, pwr_up,
    output rider_off, steer_pot, en_steer,
    input  lft_spd, rght_spd, too_fast, running
  );

  modport slave (
    input  vld, ptch, ptch_rt, pwr_up,
    input  rider_off, steer_pot, en_steer,
    output lft_spd, rght_spd, too_fast, running
  );
endinterface

// File: rtl/balance_cntrl_pipe_pid.sv
// PID core: P/I/D terms, overflow-holding integrator,
// registered and saturated PID_cntrl.
module balance_pid
  import balance_pkg::*;
#(
  parameter int SPD_W   = 12,
  parameter int I_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic                    clr,
  input  logic                    off,
  input  logic signed [15:0]      ptch,
  input  logic signed [15:0]      ptch_rt,
  output logic signed [SPD_W-1:0] pid_cntrl
);

  logic signed [17:0]      integ_q, integ_d;
  logic signed [SPD_W-1:0] pid_q, pid_d;
  logic signed [9:0]       ptch_sat;
  logic signed [18:0]      isum;
  logic signed [31:0]      p_term, i_term, d_term, total;

  always_comb begin
    if (ptch > 16'sd511)       ptch_sat = 10'sd511;
    else if (ptch < -16'sd512) ptch_sat = -10'sd512;
    else                       ptch_sat = ptch[9:0];

    p_term = P_GAIN * 32'(ptch_sat);
    i_term = 32'(integ_q >>> I_SHIFT);
    d_term = -32'(ptch_rt >>> D_SHIFT);
    total  = p_term + i_term + d_term;
    isum   = 19'(integ_q) + 19'(ptch_sat);

    integ_d = integ_q;
    pid_d   = pid_q;
    if (vld) begin
      pid_d = SPD_W'(sat(total, SPD_W));
      // hold rather than wrap when the 18-bit range is exceeded
      if (isum[18] == isum[17]) integ_d = isum[17:0];
    end
    if (clr) integ_d = '0;
    if (off) pid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
      pid_q   <= '0;
    end else begin
      integ_q <= integ_d;
      pid_q   <= pid_d;
    end
  end

  assign pid_cntrl = pid_q;

endmodule

// File: rtl/balance_cntrl_pipe.sv
// Balance controller top: power FSM, soft-start, pipeline, steer mix, too_fast.
// Optional output slew limiting under `BALANCE_SLEW_LIMIT_EN.
module balance_cntrl_pipe
  import balance_pkg::*;
#(
  parameter bit FAST_SIM    = 1'b1,
  parameter int SPD_W       = 12,
  parameter int PIPE_STAGES = 1,
  parameter int I_SHIFT     = 6,
  parameter int TOO_FAST_HI = 1536,
  parameter int TOO_FAST_LO = 1280
) (
  input logic                clk,
  input logic                rst_n,
  balance_cntrl_pipe_if.slave bus
);

  localparam int TW = FAST_SIM ? 4 : 16;

  state_e                  state_q, state_d;
  logic [7:0]              ss_q, ss_d;
  logic [TW-1:0]           div_q, div_d;
  logic                    off;
  logic signed [SPD_W-1:0] pid_cntrl, pid_ss, mix_in;
  logic signed [31:0]      prod;
  logic [11:0]             pot_c;
  logic signed [13:0]      diff;
  logic signed [15:0]      steer;
  logic signed [31:0]      tgt_l, tgt_r, abs_l, abs_r;
  logic signed [SPD_W-1:0] lft_q, lft_d, rght_q, rght_d;
  logic                    tf_q, tf_d;

  assign off = !bus.pwr_up || (state_q == OFF);

  always_comb begin
    state_d = state_q;
    ss_d    = ss_q;
    div_d   = div_q;
    unique case (state_q)
      OFF: begin
        ss_d  = '0;
        div_d = '0;
        if (bus.pwr_up) state_d = SOFT;
      end
      SOFT: begin
        div_d = div_q + 1'b1;
        if (&div_q) begin
          ss_d = ss_q + 8'd1;
          if (ss_q == 8'd254) state_d = RUN;
        end
      end
      RUN:     ss_d = 8'hFF;
      default: state_d = OFF;
    endcase
    if (!bus.pwr_up) begin
      state_d = OFF;
      ss_d    = '0;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      ss_q    <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      ss_q    <= ss_d;
      div_q   <= div_d;
    end
  end

  balance_pid #(
    .SPD_W   (SPD_W),
    .I_SHIFT (I_SHIFT)
  ) u_pid (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (bus.vld && !off),
    .clr       (bus.rider_off || off),
    .off       (off),
    .ptch      (bus.ptch),
    .ptch_rt   (bus.ptch_rt),
    .pid_cntrl (pid_cntrl)
  );

  always_comb begin
    prod   = 32'(pid_cntrl) * 32'($signed({1'b0, ss_q}));
    pid_ss = SPD_W'(prod >>> 8);
  end

  if (PIPE_STAGES == 0) begin : g_direct
    assign mix_in = pid_ss;
  end else begin : g_pipe
    logic signed [SPD_W-1:0] pipe_q [PIPE_STAGES];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= pid_ss;
        for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mix_in = pipe_q[PIPE_STAGES-1];
  end

  always_comb begin
    if (bus.steer_pot < STEER_LO)      pot_c = STEER_LO;
    else if (bus.steer_pot > STEER_HI) pot_c = STEER_HI;
    else                               pot_c = bus.steer_pot;
    diff  = $signed({2'b00, pot_c}) - $signed({2'b00, STEER_MID});
    steer = bus.en_steer ? 16'((16'(diff) * 16'sd3) >>> 4) : '0;

    tgt_l = off ? '0 : sat(32'(mix_in) + 32'(steer), SPD_W);
    tgt_r = off ? '0 : sat(32'(mix_in) - 32'(steer), SPD_W);
`ifdef BALANCE_SLEW_LIMIT_EN
    lft_d  = SPD_W'(step_to(32'(lft_q), tgt_l, SLEW_STEP));
    rght_d = SPD_W'(step_to(32'(rght_q), tgt_r, SLEW_STEP));
`else
    lft_d  = SPD_W'(tgt_l);
    rght_d = SPD_W'(tgt_r);
`endif

    abs_l = lft_q[SPD_W-1] ? -32'(lft_q) : 32'(lft_q);
    abs_r = rght_q[SPD_W-1] ? -32'(rght_q) : 32'(rght_q);
    tf_d  = tf_q;
    if (abs_l > TOO_FAST_HI || abs_r > TOO_FAST_HI)
      tf_d = 1'b1;
    else if (abs_l < TOO_FAST_LO && abs_r < TOO_FAST_LO)
      tf_d = 1'b0;
    if (off) tf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
      tf_q   <= 1'b0;
    end else begin
      lft_q  <= lft_d;
      rght_q <= rght_d;
      tf_q   <= tf_d;
    end
  end

  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;
  assign bus.too_fast = tf_q;
  assign bus.running  = (state_q == RUN);

endmodule

// File: tb/tb_balance_cntrl_pipe.sv
// Self-checking bench: per-cycle behavioural model plus
// hand-computed directed expectations.
module tb_balance_cntrl_pipe;

  localparam int SPD_W = 12;
  localparam int PIPE  = 1;
  localparam int HI    = 1536;
  localparam int LO    = 1280;
  localparam int DIVN  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  balance_cntrl_pipe_if #(.SPD_W(SPD_W)) bus ();

  balance_cntrl_pipe #(
    .FAST_SIM    (1'b1),
    .SPD_W       (SPD_W),
    .PIPE_STAGES (PIPE),
    .I_SHIFT     (6),
    .TOO_FAST_HI (HI),
    .TOO_FAST_LO (LO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int satw(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int clipp(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic int steer_of(input bit en, input int pot);
    int p;
    if (!en) return 0;
    p = pot < 512 ? 512 : (pot > 3584 ? 3584 : pot);
    return ((p - 2047) * 3) >>> 4;
  endfunction

  function automatic int toward(input int cur, input int tgt);
`ifdef BALANCE_SLEW_LIMIT_EN
    if (tgt > cur + 64) return cur + 64;
    if (tgt < cur - 64) return cur - 64;
`endif
    return tgt;
  endfunction

  // model: mode 0 off, 1 ramping, 2 running
  int m_mode, m_ss, m_div, m_int, m_pid, m_l, m_r;
  bit m_tf;
  int m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_ss = 0; m_div = 0; m_int = 0;
      m_pid = 0; m_l = 0; m_r = 0; m_tf = 0;
      m_q = {};
      for (int i = 0; i <= PIPE; i++) m_q.push_back(0);
    end else begin : upd
      int ssv, src, st, al, ar, s;
      bit off, take;
      off = !bus.pwr_up || m_mode == 0;
      ssv = (m_pid * m_ss) >>> 8;
      m_q.push_front(ssv);
      src = m_q[PIPE];
      void'(m_q.pop_back());
      al = m_l < 0 ? -m_l : m_l;
      ar = m_r < 0 ? -m_r : m_r;
      if (al > HI || ar > HI) m_tf = 1;
      else if (al < LO && ar < LO) m_tf = 0;
      if (off) m_tf = 0;
      st  = steer_of(bus.en_steer, int'(bus.steer_pot));
      m_l = toward(m_l, off ? 0 : satw(src + st));
      m_r = toward(m_r, off ? 0 : satw(src - st));
      take = bus.vld && !off;
      if (take) begin
        m_pid = satw(5 * clipp(int'(bus.ptch)) + (m_int >>> 6)
                     - (int'(bus.ptch_rt) >>> 6));
        s = m_int + clipp(int'(bus.ptch));
        if (s <= 131071 && s >= -131072) m_int = s;
      end
      if (bus.rider_off || off) m_int = 0;
      if (off) m_pid = 0;
      if (!bus.pwr_up) begin
        m_mode = 0; m_ss = 0; m_div = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_div = 0;
      end else if (m_mode == 1) begin
        if (m_div == DIVN - 1) begin
          m_ss++;
          if (m_ss == 255) m_mode = 2;
        end
        m_div = (m_div + 1) % DIVN;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_lft", int'(bus.lft_spd), m_l);
      chk("m_rght", int'(bus.rght_spd), m_r);
      chk("m_too_fast", int'(bus.too_fast), int'(m_tf));
      chk("m_running", int'(bus.running), int'(m_mode == 2));
    end
  end

  task automatic pulse(input int p, input int r);
    bus.ptch    = 16'(p);
    bus.ptch_rt = 16'(r);
    bus.vld     = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_run(input string nm, input int exp);
    int cyc;
    cyc = 0;
    while (!bus.running && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, cyc, exp);
  endtask

  task automatic chk_lr(input string nm, input int l, input int r);
    chk({nm, "_lft"}, int'(bus.lft_spd), l);
    chk({nm, "_rght"}, int'(bus.rght_spd), r);
  endtask

  initial begin
    bus.vld = 0; bus.ptch = 0; bus.ptch_rt = 0;
    bus.pwr_up = 0; bus.rider_off = 0;
    bus.steer_pot = 12'h7FF; bus.en_steer = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_lr("rst", 0, 0);
    chk("rst_too_fast", int'(bus.too_fast), 0);
    chk("rst_running", int'(bus.running), 0);

    bus.pwr_up = 1;
    wait_run("softstart_cycles", 4081);

    pulse(100, 0);
    chk_lr("lat_early", 0, 0);
    @(negedge clk);
    chk_lr("p100", 498, 498);

    bus.rider_off = 1;
    pulse(0, 0);
    pulse(0, 0);
    bus.en_steer = 1; bus.steer_pot = 12'hFFF;
    repeat (3) @(negedge clk);
    chk_lr("steer_max", 288, -288);
    bus.steer_pot = 12'h000;
    repeat (3) @(negedge clk);
    chk_lr("steer_min", -288, 288);
    bus.en_steer = 0;
    repeat (3) @(negedge clk);
    chk_lr("steer_off", 0, 0);

    pulse(320, 0);
    repeat (3) @(negedge clk);
    chk_lr("tf_1600", 1593, 1593);
    chk("tf_set", int'(bus.too_fast), 1);
    pulse(280, 0);
    repeat (3) @(negedge clk);
    chk_lr("tf_1400", 1394, 1394);
    chk("tf_hold", int'(bus.too_fast), 1);
    pulse(240, 0);
    repeat (3) @(negedge clk);
    chk_lr("tf_1200", 1195, 1195);
    chk("tf_clear", int'(bus.too_fast), 0);

    pulse(0, 6400);
    repeat (3) @(negedge clk);
    chk_lr("d_pos_rt", -100, -100);
    pulse(0, -6400);
    repeat (3) @(negedge clk);
    chk_lr("d_neg_rt", 99, 99);
    pulse(-600, 0);
    repeat (3) @(negedge clk);
    chk_lr("neg_sat", -2040, -2040);
    chk("neg_tf", int'(bus.too_fast), 1);

    repeat (300) pulse(2000, 0);
    bus.rider_off = 0;
    pulse(0, 0);
    repeat (3) @(negedge clk);
    chk_lr("rider_off_integ", 0, 0);
    repeat (300) pulse(2000, 0);
    pulse(0, 0);
    repeat (3) @(negedge clk);
    chk_lr("integ_hold", 2036, 2036);
    pulse(0, 0);
    repeat (3) @(negedge clk);
    chk_lr("integ_hold2", 2036, 2036);

    bus.pwr_up = 0;
    pulse(100, 0);
    repeat (3) @(negedge clk);
    chk_lr("pwr_fall", 0, 0);
    chk("pwr_fall_run", int'(bus.running), 0);
    chk("pwr_fall_tf", int'(bus.too_fast), 0);

    bus.pwr_up = 1;
    wait_run("softstart_again", 4081);
    pulse(100, 0);
    repeat (2) @(negedge clk);
    chk_lr("pre_rst", 498, 498);
    #3 rst_n = 0;
    #1;
    chk_lr("async_rst", 0, 0);
    chk("async_rst_run", int'(bus.running), 0);
    chk("async_rst_tf", int'(bus.too_fast), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_run", int'(bus.running), 0);
    chk_lr("post_rst", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/balance_cntrl_pipe.md
Name: balance_cntrl_pipe

Overview:
- Next-generation Segway balance controller: PID, soft-start, steering mix, saturation and too-fast detection in one block.
- Fully parametrised in widths, pipeline depth, gains and thresholds.
- Adds a power-sequencing FSM and too-fast hysteresis.
- Sits between inertial_intf/A2D_intf and the motor drive (mtr_drv) in the top level.

Parameters:
- FAST_SIM, 1, 1: soft-start tick every 2^4 clocks; 0: every 2^16 clocks
- SPD_W, 12, width of PID_cntrl and motor speed outputs (signed)
- PIPE_STAGES, 1, register stages (0..3) between PID/soft-start outputs and steering mix
- I_SHIFT, 6, integrator-to-I_term right shift (arithmetic)
- TOO_FAST_HI, 1536, |speed| above which too_fast asserts
- TOO_FAST_LO, 1280, |speed| below which too_fast deasserts (must be < TOO_FAST_HI)

Ports:
- clk  in  1  50MHz system clock
- rst_n  in  1  asynchronous active-low reset
- vld  in  1  new ptch/ptch_rt sample valid (1-clk pulse)
- ptch  in  16  signed pitch
- ptch_rt  in  16  signed pitch rate
- pwr_up  in  1  balance control enabled
- rider_off  in  1  no rider detected
- steer_pot  in  12  unsigned steering pot reading
- en_steer  in  1  steering enabled
- lft_spd  out  SPD_W  signed left motor speed
- rght_spd  out  SPD_W  signed right motor speed
- too_fast  out  1  speed near control-margin limit (hysteretic)
- running  out  1  FSM in RUN (soft-start complete)

Behaviour:
- Reset: lft_spd=0, rght_spd=0, too_fast=0, running=0, integrator=0, ss_tmr=0, all pipeline registers 0, FSM=OFF. Asynchronous, any cycle; operation mid-flight is discarded.
- FSM:
  - OFF: ss_tmr=0. Goes to SOFT when pwr_up=1.
  - SOFT: ss_tmr +1 per tick (8-bit). Goes to RUN when ss_tmr reaches 255.
  - RUN: running=1, ss_tmr held at 255.
  - Any state goes to OFF when pwr_up=0, same clock; ss_tmr and integrator clear.
- PID, updated only on vld:
  - ptch_sat = ptch clipped to [-512,+511].
  - P_term = 5*ptch_sat.
  - I_term = integrator>>>I_SHIFT, using the integrator value before this update.
  - Integrator is 18-bit signed, += sign-extended ptch_sat. If the sum would overflow, hold instead. Cleared when rider_off=1 or FSM=OFF.
  - D_term = -(ptch_rt>>>6).
  - PID_cntrl = sat_SPD_W(P_term+I_term+D_term), registered.
- Soft-start scaling: PID_ss = (PID_cntrl*ss_tmr)>>>8. Arithmetic is signed; ss_tmr is zero-extended.
- Pipeline: PID_ss passes through PIPE_STAGES registers. PIPE_STAGES=0 means a direct path.
- Steering:
  - Disabled (en_steer=0): steer=0.
  - Enabled: pot clipped to [0x200,0xE00], minus 0x7FF, then steer = (diff*3)>>>4.
- Outputs:
  - lft_spd = sat(PID_ss+steer), rght_spd = sat(PID_ss-steer), both registered.
  - Forced to 0 while FSM=OFF.
- Latency: vld at cycle N updates PID_cntrl at N+1; lft/rght_spd reflect it at N+2+PIPE_STAGES.
- too_fast: registered. Sets when |lft_spd| or |rght_spd| > TOO_FAST_HI. Clears when both < TOO_FAST_LO. Otherwise holds. Cleared in OFF.
- Simultaneous vld and pwr_up fall: OFF wins; the sample is ignored.

Optional Feature:
- Macro BALANCE_SLEW_LIMIT_EN.
- Defined: each registered output may change by at most 64 per clock toward its target. Applies to both lft_spd and rght_spd; the OFF forced-zero also ramps.
- Undefined: outputs take their target directly, as above.

Decomposition:
- Package balance_pkg: typedef of FSM states (OFF, SOFT, RUN); constants for P gain 5, D shift 6, steer clip limits 0x200/0xE00, centre 0x7FF, slew step 64; saturate function.
- One sub-module: balance_pid (P/I/D, integrator, vld handling). FSM, pipeline, mix and too_fast stay in the top.

Test Plan:
- Reset mid-RUN with outputs nonzero -> all outputs 0 asynchronously; FSM=OFF; running=0 after release.
- pwr_up=1, FAST_SIM=1 -> running rises after 255 ticks (~4080 clk); ss_tmr 255 held.
- RUN, ptch=100, ptch_rt=0, integrator=0, vld pulse -> PID_cntrl=500; PIPE_STAGES=1: lft=rght=498 at N+3.
- RUN, ptch=0, en_steer=1, steer_pot=0xFFF -> lft_spd=288, rght_spd=-288 (0xEE0); en_steer=0 -> both 0.
- Drive PID to 1600 -> too_fast=1; lower to 1400 -> stays 1; lower to 1200 -> clears.
- rider_off=1 during repeated vld with ptch=511 -> integrator stays 0; without rider_off, integrator saturates (holds), no wrap to negative.
